ram_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port synchronous RAM (address, in_data, out_data, write_enable) between two requesters, A and B.
- Each requester issues read or write transactions through a valid/ready request handshake and receives a one-cycle response pulse.
- The block sits directly in front of the RAM. It owns all RAM control signals, so no stray writes are possible.

---
 rtl/ram_arbiter.sv | 147 ++++++++++++++
 tb/tb_ram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving requesters A and B serialized access to one
// single-port synchronous RAM. It accepts one transaction at a time and
// returns a one-cycle response pulse to the requester that owns it.
module ram_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_req_valid,
  input  logic                     a_req_write,
  input  logic [ADDRESS_WIDTH-1:0] a_req_address,
  input  logic [DATA_WIDTH-1:0]    a_req_wdata,
  output logic                     a_req_ready,
  output logic                     a_rsp_valid,
  output logic [DATA_WIDTH-1:0]    a_rsp_rdata,
  input  logic                     b_req_valid,
  input  logic                     b_req_write,
  input  logic [ADDRESS_WIDTH-1:0] b_req_address,
  input  logic [DATA_WIDTH-1:0]    b_req_wdata,
  output logic                     b_req_ready,
  output logic                     b_rsp_valid,
  output logic [DATA_WIDTH-1:0]    b_rsp_rdata,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_in_data,
  output logic                     ram_write_enable,
  input  logic [DATA_WIDTH-1:0]    ram_out_data,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;       // 0 = A, 1 = B
  logic                     last_b_q, last_b_d;     // 1 = last grant went to B
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     a_rsp_valid_q, a_rsp_valid_d;
  logic                     b_rsp_valid_q, b_rsp_valid_d;
  logic [DATA_WIDTH-1:0]    a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0]    b_rdata_q, b_rdata_d;

  logic sel_a, sel_b;

  // Round-robin selection: a lone requester wins, on contention the one not granted last
  always_comb begin
    sel_a = a_req_valid && (!b_req_valid || last_b_q);
    sel_b = b_req_valid && (!a_req_valid || !last_b_q);
  end

  // Next-state, handshake and RAM control decode
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_b_d         = last_b_q;
    write_d          = write_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    a_rsp_valid_d    = 1'b0;
    b_rsp_valid_d    = 1'b0;
    a_rdata_d        = a_rdata_q;
    b_rdata_d        = b_rdata_q;
    a_req_ready      = 1'b0;
    b_req_ready      = 1'b0;
    ram_write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        a_req_ready = sel_a;
        b_req_ready = sel_b;
        if (sel_a) begin
          owner_d  = 1'b0;
          last_b_d = 1'b0;
          write_d  = a_req_write;
          addr_d   = a_req_address;
          wdata_d  = a_req_wdata;
          state_d  = ACCESS;
        end else if (sel_b) begin
          owner_d  = 1'b1;
          last_b_d = 1'b1;
          write_d  = b_req_write;
          addr_d   = b_req_address;
          wdata_d  = b_req_wdata;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        ram_write_enable = write_q;
        if (write_q) begin
          // RAM commits at this edge, so the ack is issued immediately after
          a_rsp_valid_d = !owner_q;
          b_rsp_valid_d = owner_q;
          state_d       = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (owner_q) begin
          b_rdata_d     = ram_out_data;
          b_rsp_valid_d = 1'b1;
        end else begin
          a_rdata_d     = ram_out_data;
          a_rsp_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-transaction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_b_q      <= 1'b1;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_b_q      <= last_b_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
    end
  end

  assign ram_address = addr_q;
  assign ram_in_data = wdata_q;
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign a_rsp_rdata = a_rdata_q;
  assign b_rsp_rdata = b_rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural RAM, a transaction-level
// model of arbitration and latency, and directed requester traffic.
module tb_ram_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req_valid = 1'b0, a_req_write = 1'b0;
  logic [AW-1:0] a_req_address = '0;
  logic [DW-1:0] a_req_wdata = '0;
  logic          a_req_ready, a_rsp_valid;
  logic [DW-1:0] a_rsp_rdata;
  logic          b_req_valid = 1'b0, b_req_write = 1'b0;
  logic [AW-1:0] b_req_address = '0;
  logic [DW-1:0] b_req_wdata = '0;
  logic          b_req_ready, b_rsp_valid;
  logic [DW-1:0] b_rsp_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in_data;
  logic          ram_write_enable;
  logic [DW-1:0] ram_out_data = '0;
  logic          busy;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_write(a_req_write),
    .a_req_address(a_req_address), .a_req_wdata(a_req_wdata),
    .a_req_ready(a_req_ready), .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_write(b_req_write),
    .b_req_address(b_req_address), .b_req_wdata(b_req_wdata),
    .b_req_ready(b_req_ready), .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .ram_address(ram_address), .ram_in_data(ram_in_data),
    .ram_write_enable(ram_write_enable), .ram_out_data(ram_out_data),
    .busy(busy)
  );

  // Behavioural single-port synchronous RAM
  logic [DW-1:0] tb_ram [32] = '{default: '0};
  always @(posedge clk) begin
    if (ram_write_enable) tb_ram[ram_address] <= ram_in_data;
    ram_out_data <= tb_ram[ram_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model: one outstanding transaction, fixed latencies
  typedef struct {
    bit            owner;   // 0 = A, 1 = B
    bit            rd;
    int            acc;     // cycle in which the request was accepted
    int            due;     // cycle of the response pulse
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          pend[$];
  logic [DW-1:0] mm [32] = '{default: '0};
  bit            chk_en = 1'b0;
  bit            last_b = 1'b1;
  int            free_cyc = 0;
  logic [DW-1:0] m_ra = '0, m_rb = '0;
  bit            glog[$];

  always @(negedge clk) begin : cmp
    bit            idle, era, erb, ewe, eav, ebv, addr_chk;
    logic [AW-1:0] eaddr;
    txn_t          t;
    if (chk_en) begin
      idle = (cyc >= free_cyc);
      era  = idle && a_req_valid && (!b_req_valid || last_b);
      erb  = idle && b_req_valid && (!a_req_valid || !last_b);
      check("a_req_ready", 32'(a_req_ready), 32'(era));
      check("b_req_ready", 32'(b_req_ready), 32'(erb));
      check("busy", 32'(busy), 32'(!idle));
      ewe = 1'b0; addr_chk = 1'b0; eav = 1'b0; ebv = 1'b0; eaddr = '0;
      foreach (pend[i]) begin
        if (!pend[i].rd && pend[i].acc + 1 == cyc) begin
          ewe = 1'b1; addr_chk = 1'b1; eaddr = pend[i].addr;
          check("ram_in_data", 32'(ram_in_data), 32'(pend[i].data));
        end
        if (pend[i].rd && (pend[i].acc + 1 == cyc || pend[i].acc + 2 == cyc)) begin
          addr_chk = 1'b1; eaddr = pend[i].addr;
        end
        if (pend[i].due == cyc) begin
          if (pend[i].owner) begin
            ebv = 1'b1;
            if (pend[i].rd) m_rb = pend[i].data;
          end else begin
            eav = 1'b1;
            if (pend[i].rd) m_ra = pend[i].data;
          end
          if (!pend[i].rd) check("ram_word_at_ack", 32'(tb_ram[pend[i].addr]), 32'(pend[i].data));
        end
      end
      check("ram_write_enable", 32'(ram_write_enable), 32'(ewe));
      if (addr_chk) check("ram_address", 32'(ram_address), 32'(eaddr));
      check("a_rsp_valid", 32'(a_rsp_valid), 32'(eav));
      check("b_rsp_valid", 32'(b_rsp_valid), 32'(ebv));
      check("a_rsp_rdata", 32'(a_rsp_rdata), 32'(m_ra));
      check("b_rsp_rdata", 32'(b_rsp_rdata), 32'(m_rb));
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due <= cyc) pend.delete(i);
      if (a_req_ready && a_req_valid) glog.push_back(1'b0);
      else if (b_req_ready && b_req_valid) glog.push_back(1'b1);
      if (!reset && (era || erb)) begin
        t.owner = erb;
        t.rd    = era ? !a_req_write : !b_req_write;
        t.addr  = era ? a_req_address : b_req_address;
        t.acc   = cyc;
        t.due   = cyc + (t.rd ? 3 : 2);
        if (t.rd) begin
          t.data = mm[t.addr];
        end else begin
          t.data = era ? a_req_wdata : b_req_wdata;
          mm[t.addr] = t.data;
        end
        pend.push_back(t);
        free_cyc = t.due;
        last_b   = erb;
      end
    end
    if (reset) begin
      pend.delete();
      free_cyc = cyc + 1;
      last_b   = 1'b1;
      m_ra     = '0;
      m_rb     = '0;
      chk_en   = 1'b1;
    end
  end

  // Requester agents: hold each request until ready, then present the next
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } req_t;

  req_t qa[$], qb[$];

  task automatic drive_a();
    req_t r;
    int   n;
    while (qa.size() > 0) begin
      r = qa.pop_front();
      a_req_valid = 1'b1; a_req_write = r.wr; a_req_address = r.addr; a_req_wdata = r.wd;
      n = 0;
      @(negedge clk);
      while (!a_req_ready && n < 40) begin
        n++;
        @(negedge clk);
      end
      if (!a_req_ready) begin
        check("a_handshake_timeout", 32'(a_req_ready), 32'd1);
        qa.delete();
      end
      @(posedge clk); #1;
    end
    a_req_valid = 1'b0;
  endtask

  task automatic drive_b();
    req_t r;
    int   n;
    while (qb.size() > 0) begin
      r = qb.pop_front();
      b_req_valid = 1'b1; b_req_write = r.wr; b_req_address = r.addr; b_req_wdata = r.wd;
      n = 0;
      @(negedge clk);
      while (!b_req_ready && n < 40) begin
        n++;
        @(negedge clk);
      end
      if (!b_req_ready) begin
        check("b_handshake_timeout", 32'(b_req_ready), 32'd1);
        qb.delete();
      end
      @(posedge clk); #1;
    end
    b_req_valid = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle_wait(2);

    // A writes 0x2A to address 3
    qa.push_back('{wr: 1'b1, addr: 5'd3, wd: 8'h2A});
    drive_a();
    check("p1_we_in_access", 32'(ram_write_enable), 32'd1);
    check("p1_addr_in_access", 32'(ram_address), 32'd3);
    idle_wait(1);
    check("p1_ack_at_T2", 32'(a_rsp_valid), 32'd1);
    check("p1_we_dropped", 32'(ram_write_enable), 32'd0);
    idle_wait(2);
    check("p1_ram_word3", 32'(tb_ram[3]), 32'h2A);

    // A reads address 3
    qa.push_back('{wr: 1'b0, addr: 5'd3, wd: 8'h00});
    drive_a();
    idle_wait(2);
    check("p2_rsp_at_T3", 32'(a_rsp_valid), 32'd1);
    check("p2_rdata", 32'(a_rsp_rdata), 32'h2A);
    check("p2_b_quiet", 32'(b_rsp_valid), 32'd0);
    idle_wait(2);

    // Continuous contention; last grant was A so B goes first
    g0 = glog.size();
    for (int i = 0; i < 8; i++) begin
      qa.push_back('{wr: 1'b1, addr: AW'(i), wd: DW'(i * 3)});
      qb.push_back('{wr: 1'b0, addr: 5'd31, wd: 8'h00});
    end
    fork
      drive_a();
      drive_b();
    join
    idle_wait(4);
    check("p3_grant_count", 32'(glog.size() - g0), 32'd16);
    if (glog.size() >= g0 + 16)
      for (int i = 0; i < 16; i++)
        check("p3_grant_alternates", 32'(glog[g0 + i]), 32'((i % 2 == 0) ? 1 : 0));

    // Fill every word through A, read them all back through B
    for (int i = 0; i < 32; i++) qa.push_back('{wr: 1'b1, addr: AW'(i), wd: DW'(i * 3)});
    drive_a();
    idle_wait(3);
    for (int i = 0; i < 32; i++) qb.push_back('{wr: 1'b0, addr: AW'(i), wd: 8'h00});
    drive_b();
    idle_wait(4);
    check("p4_last_rdata_addr31", 32'(b_rsp_rdata), 32'h5D);
    check("p4_ram_word0", 32'(tb_ram[0]), 32'h00);
    check("p4_ram_word31", 32'(tb_ram[31]), 32'h5D);

    // Reset during the CAPTURE cycle of a B read
    qb.push_back('{wr: 1'b0, addr: 5'd5, wd: 8'h00});
    drive_b();
    idle_wait(1);
    reset = 1'b1;
    idle_wait(1);
    reset = 1'b0;
    check("p5_busy_after_reset", 32'(busy), 32'd0);
    check("p5_rsp_dropped", 32'(b_rsp_valid), 32'd0);
    check("p5_rdata_cleared", 32'(b_rsp_rdata), 32'd0);
    idle_wait(1);
    g0 = glog.size();
    qa.push_back('{wr: 1'b0, addr: 5'd5, wd: 8'h00});
    qb.push_back('{wr: 1'b0, addr: 5'd6, wd: 8'h00});
    fork
      drive_a();
      drive_b();
    join
    idle_wait(4);
    check("p5_grants_after_reset", 32'(glog.size() - g0), 32'd2);
    if (glog.size() > g0) check("p5_first_grant_A", 32'(glog[g0]), 32'd0);
    check("p5_b_read6", 32'(b_rsp_rdata), 32'h12);

    // A read accepted in the same cycle as B's write ack
    qb.push_back('{wr: 1'b1, addr: 5'd9, wd: 8'hC3});
    qa.push_back('{wr: 1'b0, addr: 5'd9, wd: 8'h00});
    fork
      drive_b();
      begin
        @(posedge clk); #1;
        drive_a();
      end
    join
    idle_wait(1);
    check("p6_we_low_in_capture", 32'(ram_write_enable), 32'd0);
    idle_wait(1);
    check("p6_read_pulse", 32'(a_rsp_valid), 32'd1);
    check("p6_read_after_write", 32'(a_rsp_rdata), 32'hC3);
    idle_wait(3);
    check("p6_model_drained", 32'(pend.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
